// File: rtl/disp_buf_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// disp_buf_arbiter_pkg
// Shared constants and helpers for the seven-segment display buffer:
//   - blank / dash segment codes (active-low, bit7 = dp, bits6..0 = g..a)
//   - 16-entry hex-to-segment table
//   - ASCII range constants used by the UART character decoder
//   - digit slice helper (digit 0 is the leftmost, in the top byte)
// No ports (package).
// -----------------------------------------------------------------------------
package disp_buf_arbiter_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] BLANK_CODE = 8'hFF;
  localparam logic [7:0] DASH_CODE  = 8'hBF;

  // Element n is the segment code for hex digit n; dp is kept off (bit7 = 1).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UC_A  = 8'h41;
  localparam logic [7:0] ASCII_UC_F  = 8'h46;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_F  = 8'h66;

  // Which requester received the most recent grant.
  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_t;

  // Result of classifying an incoming ASCII byte.
  typedef enum logic [1:0] {
    ASC_HEX   = 2'd0,
    ASC_BLANK = 2'd1,
    ASC_DASH  = 2'd2
  } ascii_class_t;

  // LSB position of digit idx inside the 64-bit buffer: digit 0 -> bit 56.
  function automatic logic [5:0] digit_lsb(input logic [2:0] idx);
    return 6'd56 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/disp_buf_arbiter_if.sv
// -----------------------------------------------------------------------------
// disp_buf_arbiter_if
// Bundles the two requester handshakes, the clear pulse and the display
// outputs of the display buffer arbiter.
//   master : requester / consumer side (drives clr, req*_valid and payloads)
//   slave  : the arbiter (drives req*_ready, display, disp_upd)
// Signals:
//   clr            synchronous clear pulse
//   req0_valid/data/ready    UART ASCII stream (shift-in from the right)
//   req1_valid/addr/nibble/ready  direct hex write to one digit
//   display        64-bit segment buffer, digit i at [63-8i : 56-8i]
//   disp_upd       one-cycle pulse the cycle after any buffer write
// -----------------------------------------------------------------------------
interface disp_buf_arbiter_if;
  logic        clr;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [2:0]  req1_addr;
  logic [3:0]  req1_nibble;
  logic        req1_ready;
  logic [63:0] display;
  logic        disp_upd;

  modport master (
    output clr, req0_valid, req0_data, req1_valid, req1_addr, req1_nibble,
    input  req0_ready, req1_ready, display, disp_upd
  );

  modport slave (
    input  clr, req0_valid, req0_data, req1_valid, req1_addr, req1_nibble,
    output req0_ready, req1_ready, display, disp_upd
  );
endinterface

// File: rtl/disp_buf_arbiter_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to seven-segment code lookup (active-low, dp off).
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_code    out 8  segment code
// -----------------------------------------------------------------------------
module hex_to_seg7
  import disp_buf_arbiter_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_code
);

  assign o_code = HEX_SEG[i_nibble];

endmodule

// File: rtl/disp_buf_arbiter.sv
// -----------------------------------------------------------------------------
// disp_buf_arbiter
// Owns the 64-bit segment buffer feeding the 8-digit scan controller.
// Requester 0 (UART) scrolls ASCII characters in from the right; requester 1
// writes a hex nibble to one addressed digit. A round-robin arbiter grants at
// most one write per cycle; clr overrides both and blanks the buffer.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of disp_buf_arbiter_if (handshakes, clr, display,
//         disp_upd)
// -----------------------------------------------------------------------------
module disp_buf_arbiter #(
  parameter logic [7:0] BLANK_CODE = disp_buf_arbiter_pkg::BLANK_CODE,
  parameter logic [7:0] DASH_CODE  = disp_buf_arbiter_pkg::DASH_CODE
) (
  input  logic                clk,
  input  logic                rst,
  disp_buf_arbiter_if.slave   bus
);
  import disp_buf_arbiter_pkg::*;

  logic [63:0]   r_display;
  logic          r_disp_upd;
  grant_t        r_last_grant;

  logic [3:0]    w_ascii_nibble;
  ascii_class_t  w_ascii_class;
  logic [7:0]    w_seg0;
  logic [7:0]    w_seg1;
  logic [7:0]    w_ascii_code;
  logic          w_arb_en;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_write;
  logic [63:0]   w_display_next;

  // ---------------------------------------------------------------------------
  // ASCII classification: digits map directly, A-F / a-f map to 10..15 via
  // the low nibble (which is 1..6 for those letters), space blanks, anything
  // else shows a dash.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ascii_nibble = 4'h0;
    w_ascii_class  = ASC_DASH;
    if (bus.req0_data >= ASCII_0 && bus.req0_data <= ASCII_9) begin
      w_ascii_nibble = bus.req0_data[3:0];
      w_ascii_class  = ASC_HEX;
    end else if ((bus.req0_data >= ASCII_UC_A && bus.req0_data <= ASCII_UC_F) ||
                 (bus.req0_data >= ASCII_LC_A && bus.req0_data <= ASCII_LC_F)) begin
      w_ascii_nibble = bus.req0_data[3:0] + 4'd9;
      w_ascii_class  = ASC_HEX;
    end else if (bus.req0_data == ASCII_SPACE) begin
      w_ascii_class  = ASC_BLANK;
    end
  end

  hex_to_seg7 u_seg_ascii (
    .i_nibble (w_ascii_nibble),
    .o_code   (w_seg0)
  );

  hex_to_seg7 u_seg_direct (
    .i_nibble (bus.req1_nibble),
    .o_code   (w_seg1)
  );

  always_comb begin
    case (w_ascii_class)
      ASC_HEX:   w_ascii_code = w_seg0;
      ASC_BLANK: w_ascii_code = BLANK_CODE;
      default:   w_ascii_code = DASH_CODE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. Grants are combinational so ready is a same-cycle
  // acknowledge; ready is forced low during reset and while clr is high.
  // On contention the requester that did not win last time is served.
  // ---------------------------------------------------------------------------
  assign w_arb_en = !rst && !bus.clr;
  assign w_grant0 = w_arb_en && bus.req0_valid &&
                    (!bus.req1_valid || r_last_grant == GRANT_REQ1);
  assign w_grant1 = w_arb_en && bus.req1_valid &&
                    (!bus.req0_valid || r_last_grant == GRANT_REQ0);
  assign w_write  = bus.clr || w_grant0 || w_grant1;

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  // ---------------------------------------------------------------------------
  // Buffer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_display_next = r_display;
    if (bus.clr) begin
      w_display_next = {NUM_DIGITS{BLANK_CODE}};
    end else if (w_grant0) begin
      // New character enters at the right, leftmost digit falls off.
      w_display_next = {r_display[55:0], w_ascii_code};
    end else if (w_grant1) begin
      w_display_next[digit_lsb(bus.req1_addr) +: 8] = w_seg1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_display    <= {NUM_DIGITS{BLANK_CODE}};
      r_disp_upd   <= 1'b0;
      r_last_grant <= GRANT_REQ1;
    end else begin
      if (w_write) begin
        r_display <= w_display_next;
      end
      // Pulses on every write, even one that leaves the buffer unchanged.
      r_disp_upd <= w_write;
      if (w_grant0) begin
        r_last_grant <= GRANT_REQ0;
      end else if (w_grant1) begin
        r_last_grant <= GRANT_REQ1;
      end
    end
  end

  assign bus.display  = r_display;
  assign bus.disp_upd = r_disp_upd;

endmodule

// File: doc/disp_buf_arbiter.md
Name: disp_buf_arbiter

Overview:
Owns the 64-bit segment-code buffer that drives the 8-digit seven-segment scan controller.
- Requester 0 is the UART receive path. It streams ASCII characters that scroll into the display from the right.
- Requester 1 is local logic. It writes a hex nibble directly to an addressed digit.
- Round-robin arbitration allows one buffer write per cycle. Clear has priority over both requesters. The buffer output feeds the scanner's display input.

Parameters:
BLANK_CODE, 8'hFF, segment code for an unlit digit (active-low segments).
DASH_CODE, 8'hBF, segment code shown for unrecognised ASCII (segment g only).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear pulse; blanks all digits
req0_valid  input  1  UART byte available
req0_data  input  8  ASCII character
req0_ready  output  1  byte accepted this cycle (combinational grant)
req1_valid  input  1  direct digit write request
req1_addr  input  3  digit index; 0 = leftmost = display[63:56]
req1_nibble  input  4  hex value to show
req1_ready  output  1  write accepted this cycle (combinational grant)
display  output  64  segment codes; digit i occupies bits [63-8i : 56-8i]
disp_upd  output  1  one-cycle pulse, the cycle after any buffer change

Behaviour:
Segment code format:
- bit7 = dp, bits6..0 = g..a, active-low.
- Hex codes 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- dp is always 1 (off).

Reset:
- display = {8{BLANK_CODE}}, disp_upd = 0, last_grant = 1 (requester 0 wins the first tie).
- req*_ready are 0 while rst is high.

Arbitration (combinational, same cycle as valid):
- Only one valid: that requester is granted.
- Both valid: grant goes to the requester not in last_grant. last_grant updates on every grant.
- clr high: both ready = 0, no grant, last_grant unchanged.
- Handshake: transfer happens when valid && ready. An ungranted requester must hold valid and data until it is granted. The block does not buffer requests.

Write effects, registered, visible on display the cycle after the grant:
- Requester 0 shift-in: display <= {display[55:0], code(req0_data)}. The leftmost digit is discarded.
- ASCII decode for code():
  - 0x30-0x39 → hex 0-9.
  - 0x41-0x46 and 0x61-0x66 → A-F.
  - 0x20 → BLANK_CODE.
  - Any other byte, including CR/LF → DASH_CODE.
- Requester 1: only digit req1_addr is replaced with hex code(req1_nibble). All other digits are unchanged.
- clr: display <= all BLANK_CODE on the next edge.

disp_upd:
- Asserted for exactly one cycle, the cycle after an accepted write or clr.
- It is asserted even if the new value equals the old value.
- Back-to-back grants keep it high continuously.

Reset mid-operation: asynchronous return to reset values. Any pending request must be re-presented after reset is released.

Throughput: one write per cycle. Neither requester starves; under sustained contention each is granted at least every other cycle.

Decomposition:
Shared package (disp_pkg) holds:
- BLANK_CODE, DASH_CODE.
- The 16-entry hex segment table.
- The ASCII range constants.
- The digit-slice index helper.

One natural combinational sub-module, hex_to_seg7 (4-bit in, 8-bit code out):
- Instance 0 serves the ASCII path after nibble extraction.
- Instance 1 serves the direct-write path.

ASCII classification, arbiter and buffer register stay in the top module.

Test Plan:
1. Reset, then release → display = 64'hFFFF_FFFF_FFFF_FFFF, disp_upd = 0, both ready low during reset.
2. req0 sends "1","2","A","z" on consecutive cycles → after the 4th grant, the rightmost four digits are F9 A4 88 BF, the upper four stay FF, and disp_upd is high for 4 consecutive cycles.
3. req1 writes addr=0 nibble=8, then addr=7 nibble=F → display[63:56]=80 and display[7:0]=8E; other digits unchanged.
4. req0 and req1 both valid for 4 cycles from reset → grants go 0,1,0,1, with ready exclusive each cycle. Display reflects interleaved shifts and writes in that order.
5. clr asserted while both are valid → both ready = 0 that cycle. Next cycle display is all FF and disp_upd = 1. Arbitration resumes with the same last_grant.
6. Nine shift-ins "0".."8" → digit 0 (the first "0") has been shifted out. Display = F9 A4 B0 99 92 82 F8 80 (digits 1..8).
